spi_master_rw: RTL
==================

Name: spi_master_rw

Overview:
Synthesizable SPI mode-0 master for register access: one transaction is an address phase followed by a data phase, with write or read. Generalised in address/data width, SCLK divider and chip-select count. Read data is captured from the slave during the data phase. Sits between a local control FSM/CPU bus and external SPI slave devices; replaces bench-only SPI stimulus in integrated designs.

Parameters:
AW, 8, address phase bit count (>=1)
DW, 8, data phase bit count (>=1)
DIV, 50, CLK cycles per SCLK half-period (>=1)
NCS, 1, number of chip-select lines (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RSTX  in  1  synchronous active-low reset
START  in  1  request; sampled only when BUSY=0
RW  in  1  1=read, 0=write; latched with START
CSSEL  in  max(1,clog2(NCS))  chip select index; latched with START
ADDR  in  AW  address; latched with START
WDATA  in  DW  write data; latched with START
BUSY  out  1  transaction in progress
DONE  out  1  one-cycle completion pulse
RDATA  out  DW  last read data
CS  out  NCS  active-low chip selects
SCLK  out  1  serial clock, idle low
SDATA  out  1  master serial out
SDI  in  1  slave serial in

Behaviour:
- Reset (RSTX=0 at CLK edge): CS all 1, SCLK=0, SDATA=0, BUSY=0, DONE=0, RDATA=0, FSM to IDLE. Reset mid-transfer aborts immediately; no DONE.
- All outputs registered.
- States: IDLE -> SETUP -> (LOW, HIGH) x (AW+DW) -> TAIL -> GAP -> IDLE. Every non-IDLE state lasts exactly DIV CLK cycles, counted by a half-period counter.
- IDLE: START=1 latches RW/CSSEL/ADDR/WDATA and enters SETUP on the same edge. BUSY=1 from the next cycle.
- SETUP: CS[CSSEL]=0, SCLK=0, SDATA=0.
- LOW: SCLK=0, SDATA=current bit.
- HIGH: SCLK=1, SDATA holds the same bit. The slave samples on the rising edge.
- Bit order is LSB first: ADDR[0..AW-1], then WDATA[0..DW-1].
- Read: SDATA=0 throughout the data phase. SDI is sampled in the last CLK cycle of each data-phase HIGH and shifted in LSB first.
- TAIL: SCLK=0, SDATA=0, CS still asserted.
- GAP: CS all 1.
- Exit from GAP: BUSY=0 and DONE=1 for one cycle, same edge. On a read, RDATA is updated on this edge. On a write, RDATA keeps its previous value.
- Transaction length: (2*(AW+DW)+3)*DIV cycles of BUSY=1.
- START while BUSY=1 is ignored (not queued). START on the DONE cycle is accepted.
- CSSEL>=NCS: the transaction runs with all CS held high, and DONE still pulses.
- Input changes after acceptance have no effect.

Optional Feature:
SPI_MSB_FIRST_EN:
- Defined: both phases shift MSB first (ADDR[AW-1] first, WDATA[DW-1] first). Read data is assembled MSB first (first sampled bit goes to RDATA[DW-1]).
- Undefined: LSB first, as above.
- Timing is identical in both cases.

Test Plan:
Common setup: AW=8, DW=8, DIV=2, NCS=2.
1. Reset: hold RSTX=0 for 3 cycles -> CS=2'b11, SCLK=0, SDATA=0, BUSY=0, DONE=0, RDATA=0x00.
2. Write: ADDR=0x5A, WDATA=0xC3, CSSEL=1 -> CS=2'b01 for the transfer. SDATA at each SCLK rise is 0,1,0,1,1,0,1,0 then 1,1,0,0,0,0,1,1. 16 SCLK pulses, BUSY high 70 cycles, then DONE pulse. RDATA unchanged.
3. Read: ADDR=0x81, CSSEL=0, slave model drives 0x96 LSB first, changing on SCLK fall -> SDATA=0 in data phase, CS=2'b10, RDATA=0x96 on the DONE cycle.
4. Back-to-back: pulse START at cycle 10 of a busy transfer -> ignored. START held high on the DONE cycle -> new transfer begins, CS reasserted after the 2-cycle GAP.
5. Reset mid-transfer: RSTX=0 during the 5th HIGH -> next edge CS=2'b11, SCLK=0, BUSY=0, no DONE. After release, a new write completes normally.
6. With SPI_MSB_FIRST_EN: write ADDR=0x01, WDATA=0x80 -> SDATA sequence is seven 0s then 1, followed by 1 then seven 0s. A read of slave value 0x96 sent MSB first gives RDATA=0x96.

Source files
------------

// File: rtl/spi_master_rw.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_rw
// Brief    : SPI mode-0 register-access master (address phase, then data phase).
//            Define SPI_MSB_FIRST_EN to shift MSB first; the default is LSB first.
// Revision : 1.0
// ============================================================================
module spi_master_rw #(
    parameter int AW  = 8,
    parameter int DW  = 8,
    parameter int DIV = 50,
    parameter int NCS = 1
) (
    input  logic                                    clk,
    input  logic                                    rstx,
    input  logic                                    start,
    input  logic                                    rw,
    input  logic [((NCS > 1) ? $clog2(NCS) : 1)-1:0] cssel,
    input  logic [AW-1:0]                           addr,
    input  logic [DW-1:0]                           wdata,
    output logic                                    busy,
    output logic                                    done,
    output logic [DW-1:0]                           rdata,
    output logic [NCS-1:0]                          cs,
    output logic                                    sclk,
    output logic                                    sdata,
    input  logic                                    sdi
);

    localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;
    localparam int NB  = AW + DW;
    localparam int BW  = $clog2(NB + 1);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_TAIL  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [BW-1:0]  r_bit;
    logic [NB-1:0]  r_sh;
    logic [DW-1:0]  r_rx;
    logic           r_rw;

    logic           w_last;
    logic           w_bit;
    logic [DW-1:0]  w_wd;
    logic [NB-1:0]  w_load;
    logic [NB-1:0]  w_sh_next;
    logic [DW-1:0]  w_rx_next;
    logic [NCS-1:0] w_cs_sel;

    assign w_last = (r_cnt == CW'(DIV - 1));
    // A read shifts zeros out during the data phase, so the write data is masked at load.
    assign w_wd   = rw ? '0 : wdata;

`ifdef SPI_MSB_FIRST_EN
    assign w_load    = {addr, w_wd};
    assign w_bit     = r_sh[NB-1];
    assign w_sh_next = r_sh << 1;
    assign w_rx_next = (r_rx << 1) | DW'(sdi);
`else
    assign w_load    = {w_wd, addr};
    assign w_bit     = r_sh[0];
    assign w_sh_next = r_sh >> 1;
    assign w_rx_next = (r_rx >> 1) | (DW'(sdi) << (DW - 1));
`endif

    // An out-of-range select leaves every line deasserted.
    generate
        for (genvar gi = 0; gi < NCS; gi++) begin : g_cs
            assign w_cs_sel[gi] = (cssel != CSW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstx) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_rx    <= '0;
            r_rw    <= 1'b0;
            cs      <= '1;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (start) begin
                    r_state <= S_SETUP;
                    r_rw    <= rw;
                    r_sh    <= w_load;
                    r_bit   <= '0;
                    cs      <= w_cs_sel;
                    busy    <= 1'b1;
                    sclk    <= 1'b0;
                    sdata   <= 1'b0;
                end
            end else if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
                case (r_state)
                    S_SETUP: begin
                        r_state <= S_LOW;
                        sdata   <= w_bit;
                        r_sh    <= w_sh_next;
                    end
                    S_LOW: begin
                        r_state <= S_HIGH;
                        sclk    <= 1'b1;
                    end
                    S_HIGH: begin
                        sclk <= 1'b0;
                        if (r_rw && (r_bit >= BW'(AW))) begin
                            r_rx <= w_rx_next;
                        end
                        if (r_bit == BW'(NB - 1)) begin
                            r_state <= S_TAIL;
                            sdata   <= 1'b0;
                        end else begin
                            r_state <= S_LOW;
                            r_bit   <= r_bit + BW'(1);
                            sdata   <= w_bit;
                            r_sh    <= w_sh_next;
                        end
                    end
                    S_TAIL: begin
                        r_state <= S_GAP;
                        cs      <= '1;
                    end
                    S_GAP: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (r_rw) begin
                            rdata <= r_rx;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
